// File: rtl/seq_priority_encoder_8to3.sv
// seq_priority_encoder_8to3: accepts a request vector and streams the index of
// each set bit, one per output handshake, in priority order.
module seq_priority_encoder_8to3 #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_vec,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_idx,
   output logic       out_last,
   output logic       zero_pulse
);
   typedef enum logic {IDLE, EMIT} state_t;

   state_t     state;
   logic [7:0] pending;
   logic [7:0] nxt_pend;
   logic       accept;
   logic       fire;

   // Scan from lowest to highest priority so the last hit wins.
   function automatic logic [2:0] prio(input logic [7:0] v);
      logic [2:0] p;
      p = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[MSB_FIRST ? i : 7 - i]) p = MSB_FIRST ? 3'(i) : 3'(7 - i);
      return p;
   endfunction

   assign in_ready  = state == IDLE;
   assign out_valid = state == EMIT;
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready;

   always_comb begin
      nxt_pend = accept ? in_vec : fire ? pending & ~(8'd1 << out_idx) : pending;
   end

   // Index and last flag are precomputed from the next pending value so that
   // every output comes straight from a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= 8'd0;
         out_idx    <= 3'd0;
         out_last   <= 1'b0;
         zero_pulse <= 1'b0;
      end else begin
         pending    <= nxt_pend;
         zero_pulse <= accept && in_vec == 8'd0;
         if (accept && in_vec != 8'd0) state <= EMIT;
         else if (fire && out_last) state <= IDLE;
         if (nxt_pend != 8'd0) begin
            out_idx  <= prio(nxt_pend);
            out_last <= (nxt_pend & (nxt_pend - 8'd1)) == 8'd0;
         end
      end
   end
endmodule
